inst_fetch_unit: RTL
====================

// Module: inst_fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of control_logic.
//  Holds the fetch PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
//  Buffers returned words in a small FIFO and presents {inst, inst_pc, inst_pc4} to decode and control.
//  Redirects on PCSel=1, taking the target from the ALU result (branch/jump path).
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch address loaded on reset
//  FIFO_DEPTH  2              instruction buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst_n       in   1   reset, synchronous, active-low
//  clk_en      in   1   stage enable; 0 freezes all state
//  PCSel       in   1   1 = redirect fetch to alu_out (from control_logic)
//  alu_out     in   32  redirect target address
//  dec_ready   in   1   downstream accepts inst this cycle
//  imem_req    out  1   read request valid
//  imem_addr   out  32  word-aligned read address
//  imem_gnt    in   1   request accepted when imem_req && imem_gnt
//  imem_rvalid in   1   read data valid; >=1 cycle after grant, in order
//  imem_rdata  in   32  instruction word
//  inst        out  32  head instruction; 32'h0000_0013 (NOP) when empty
//  inst_pc     out  32  PC of head instruction; 0 when empty
//  inst_pc4    out  32  inst_pc + 4 (mod 2^32)
//  inst_valid  out  1   FIFO non-empty
//  misalign    out  1   only with FETCH_MISALIGN_TRAP_EN
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - fetch_pc=RESET_PC; FIFO empty; outstanding=0; state=REQ.
//    - Outputs: imem_req=0, inst_valid=0, inst=NOP, inst_pc=0, misalign=0.
//  - FSM states:
//    - REQ:  imem_req=1 iff clk_en && (count+outstanding < FIFO_DEPTH); imem_addr=fetch_pc.
//      Grant: fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding=1, go to WAIT.
//    - WAIT: imem_req=0. On rvalid: push {imem_rdata, pc}, outstanding=0, go to REQ.
//    - DROP: imem_req=0. On rvalid: discard data, outstanding=0, go to REQ.
//  - At most one request is outstanding. A push can never overflow the FIFO.
//  - Pop when inst_valid && dec_ready. A push and a pop in the same cycle leave count unchanged.
//  - Latency: grant at cycle N, rvalid at N+1 -> inst_valid=1 at N+2 (registered FIFO head).
//  - Redirect (clk_en && PCSel=1) overrides everything else that cycle:
//    - FIFO flushed (count=0); any same-cycle pop or push is ignored.
//    - fetch_pc = {alu_out[31:2], 2'b00}.
//    - If a request is outstanding, or granted this same cycle -> DROP; else -> REQ.
//    - imem_req is forced 0 in the redirect cycle.
//  - clk_en=0: no state changes; imem_req=0. A pending rvalid is still captured (memory is not stallable).
//  - Reset mid-operation: an in-flight response arriving after reset is ignored (outstanding=0, state REQ).
// CONFIGURATION
//  FETCH_MISALIGN_TRAP_EN defined:
//    - Redirect with alu_out[1:0]!=0 sets misalign=1 (sticky until reset).
//    - Fetching stops (imem_req=0) and the FIFO is flushed.
//  Not defined:
//    - No misalign port; alu_out[1:0] silently truncated.
// TESTING
//  1. Reset, imem_gnt=1, rvalid 1 cycle after grant, dec_ready=1 ->
//     imem_addr 0,4,8,...; inst_valid first at cycle 2; inst_pc4=inst_pc+4.
//  2. dec_ready=0 ->
//     2 entries fill, imem_req drops to 0.
//     dec_ready=1 -> pops in order, fetch resumes at next address.
//  3. PCSel=1, alu_out=32'h0000_0100 while a request is outstanding ->
//     returned word discarded, FIFO empty, next imem_addr=32'h100.
//  4. fetch_pc=32'hFFFF_FFFC granted -> next imem_addr=32'h0; inst_pc4 of that entry=32'h0.
//  5. clk_en=0 for 5 cycles with FIFO full ->
//     outputs unchanged, imem_req=0; resumes cleanly when clk_en=1.
//  6. With FETCH_MISALIGN_TRAP_EN: PCSel=1, alu_out=32'h102 ->
//     misalign=1, imem_req stays 0 until rst_n=0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: fetch PC, single-outstanding imem req/gnt/rvalid port, small in-order
// instruction buffer. Optional FETCH_MISALIGN_TRAP_EN adds a sticky misaligned-redirect trap.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        PCSel,
  input  logic [31:0] alu_out,
  input  logic        dec_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc4,
  output logic        inst_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e            state_q, state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]       inst_mem_q [FIFO_DEPTH];
  logic [31:0]       pc_mem_q   [FIFO_DEPTH];

  logic redirect;
  logic gnt_fire;
  logic push;
  logic pop;
  logic fetch_stop;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q;
    if (redirect && (alu_out[1:0] != 2'b00)) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign   = misalign_q;
  assign fetch_stop = misalign_q;
`else
  logic unused_alu_lsb;
  assign unused_alu_lsb = ^alu_out[1:0];
  assign fetch_stop     = 1'b0;
`endif

  // Handshake and FIFO control; a redirect dominates every other event in its cycle.
  always_comb begin
    redirect   = clk_en & PCSel;
    inst_valid = (count_q != '0);
    imem_addr  = fetch_pc_q;
    imem_req   = rst_n & clk_en & ~PCSel & ~fetch_stop & (state_q == StReq) &
                 (count_q < DepthCnt);
    gnt_fire   = imem_req & imem_gnt;
    push       = (state_q == StWait) & imem_rvalid & ~redirect;
    pop        = clk_en & inst_valid & dec_ready & ~redirect;
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    unique case (state_q)
      StReq: begin
        if (gnt_fire) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = StWait;
        end
      end
      StWait, StDrop: begin
        // Responses are captured regardless of clk_en: memory cannot be stalled.
        if (imem_rvalid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end

    if (redirect) begin
      fetch_pc_d = {alu_out[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A response arriving in the redirect cycle retires the outstanding request.
      if ((state_q != StReq && !imem_rvalid) || gnt_fire) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StReq;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Only one request is ever in flight, so its PC is the fetch PC minus one word.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q - 32'd4;
    end
  end

  always_comb begin
    inst     = Nop;
    inst_pc  = 32'h0;
    if (inst_valid) begin
      inst    = inst_mem_q[rd_ptr_q];
      inst_pc = pc_mem_q[rd_ptr_q];
    end
    inst_pc4 = inst_pc + 32'd4;
  end

endmodule
